// File: rtl/wb_uart_fifo.sv
// Wishbone (classic, 32-bit) UART with TX/RX FIFOs, status/control registers and a TX launch FSM.
// Define UART_WB_LOOPBACK_EN to implement the CTRL[3] internal loopback (tx_o -> rx_i).

module uart #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 19200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_vld,
    output logic       tx_active,
    output logic       tx_o,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    output logic       rx_parity_err
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CPB + 1);
    localparam int PB = (PARITY_TYPE != 0) ? 1 : 0;
    localparam int FRAME = 2 + DATA_BITS + PB + STOP_BITS;
    localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);

    logic [11:0]   tx_shift, frame;
    logic [3:0]    tx_left;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [7:0]    tx_d;
    logic [1:0]    rx_sync;
    logic          rx_s, rx_busy, rx_par;
    logic [3:0]    rx_idx;
    logic [8:0]    rx_bits;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        tx_d  = tx_data & DMASK;
        frame = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < DATA_BITS) frame[i+1] = tx_d[i];
        if (PB == 1) frame[DATA_BITS+1] = (PARITY_TYPE == 1) ? ~^tx_d : ^tx_d;
    end

    assign tx_active = (tx_left != 4'd0);
    assign tx_o      = tx_active ? tx_shift[0] : 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '1;
            tx_left  <= '0;
            tx_cnt   <= '0;
        end else if (!tx_active) begin
            if (tx_data_vld) begin
                tx_shift <= frame;
                tx_left  <= 4'(FRAME);
                tx_cnt   <= CW'(CPB - 1);
            end
        end else if (tx_cnt == '0) begin
            tx_shift <= {1'b1, tx_shift[11:1]};
            tx_left  <= tx_left - 4'd1;
            tx_cnt   <= CW'(CPB - 1);
        end else begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    assign rx_s   = rx_sync[1];
    assign rx_par = ^(rx_bits[7:0] & DMASK) ^ rx_bits[DATA_BITS];

    // Receiver samples mid-bit: half a bit after the start edge, then once per bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync       <= '1;
            rx_busy       <= 1'b0;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_bits       <= '0;
            rx_data       <= '0;
            rx_data_vld   <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_sync       <= {rx_sync[0], rx_i};
            rx_data_vld   <= 1'b0;
            rx_parity_err <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(CPB / 2 - 1);
                    rx_idx  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CW'(CPB - 1);
                if (rx_idx == 4'd0) begin
                    if (rx_s) rx_busy <= 1'b0;
                    else      rx_idx  <= 4'd1;
                end else if (rx_idx <= 4'(DATA_BITS + PB)) begin
                    rx_bits[rx_idx - 4'd1] <= rx_s;
                    rx_idx <= rx_idx + 4'd1;
                end else begin
                    rx_busy       <= 1'b0;
                    rx_data_vld   <= 1'b1;
                    rx_data       <= rx_bits[7:0] & DMASK;
                    rx_parity_err <= (PB == 1) && (rx_par == (PARITY_TYPE != 1));
                end
            end
        end
    end
endmodule

module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A simultaneous push and pop always both happen: full stays full, empty falls through.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);
    assign rd_data = empty ? wr_data : mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wptr] <= wr_data;
    end
endmodule

module wb_uart_fifo #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 19200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 0,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;
    localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);

    tx_state_t state, state_nxt;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic        req, bus_err, ctrl_wr, tx_push, tx_pop, tx_flush, rx_pop, rx_flush, flag_clear;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_busy, loopback;
    logic        rx_overrun, parity_err, rx_underrun;
    logic [7:0]  tx_head, tx_hold, rx_head, core_tx_data, core_rx_data;
    logic        core_tx_vld, core_tx_active, core_tx, core_rx, core_rx_vld, core_perr;
    logic [31:0] status, rdata;
    logic        unused_bits;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8]};

    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign bus_err    = req & wb_we_i & (wb_adr_i[3:2] == 2'd0) & tx_full & ~tx_pop;
    assign tx_push    = req & wb_we_i & (wb_adr_i[3:2] == 2'd0) & ~bus_err;
    assign rx_pop     = req & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign ctrl_wr    = req & wb_we_i & (wb_adr_i[3:2] == 2'd2);
    assign tx_flush   = ctrl_wr & wb_dat_i[0];
    assign rx_flush   = ctrl_wr & wb_dat_i[1];
    assign flag_clear = ctrl_wr & wb_dat_i[2];
    assign tx_busy    = (state != IDLE);

    assign status = {8'd0, 8'(tx_count), 8'(rx_count), rx_underrun, parity_err, rx_overrun,
                     tx_busy, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rdata = '0;
        case (wb_adr_i[3:2])
            2'd0:    rdata = (rx_empty && !core_rx_vld) ? 32'd0 : {24'd0, rx_head};
            2'd1:    rdata = status;
            2'd2:    rdata = {28'd0, loopback, 3'b000};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            rx_overrun  <= 1'b0;
            parity_err  <= 1'b0;
            rx_underrun <= 1'b0;
            state       <= IDLE;
            tx_hold     <= '0;
        end else begin
            wb_ack_o    <= req & ~bus_err;
            wb_err_o    <= bus_err;
            wb_dat_o    <= (req && !wb_we_i) ? rdata : 32'd0;
            // A new error event in the same cycle as flag_clear leaves the flag set.
            rx_overrun  <= (core_rx_vld & rx_full & ~rx_pop & ~rx_flush) | (rx_overrun & ~flag_clear);
            parity_err  <= (core_perr & ~rx_flush) | (parity_err & ~flag_clear);
            rx_underrun <= (rx_pop & rx_empty & ~core_rx_vld) | (rx_underrun & ~flag_clear);
            state       <= state_nxt;
            if (state == LAUNCH) tx_hold <= tx_head;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_pop      = 1'b0;
        core_tx_vld = 1'b0;
        case (state)
            IDLE:      if (!tx_empty && !core_tx_active) state_nxt = LAUNCH;
            LAUNCH: begin
                tx_pop      = 1'b1;
                core_tx_vld = 1'b1;
                state_nxt   = WAIT_BUSY;
            end
            WAIT_BUSY: if (core_tx_active) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!core_tx_active) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign core_tx_data = (state == LAUNCH) ? tx_head : tx_hold;

`ifdef UART_WB_LOOPBACK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      loopback <= 1'b0;
        else if (ctrl_wr) loopback <= wb_dat_i[3];
    end
    assign core_rx   = loopback ? core_tx : uart_rx_i;
    assign uart_tx_o = loopback ? 1'b1 : core_tx;
`else
    assign loopback  = 1'b0;
    assign core_rx   = uart_rx_i;
    assign uart_tx_o = core_tx;
`endif

    uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
        .wr_data(wb_dat_i[7:0] & DMASK), .rd_data(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush(rx_flush), .push(core_rx_vld), .pop(rx_pop),
        .wr_data(core_rx_data), .rd_data(rx_head), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    uart #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(DATA_BITS),
        .PARITY_TYPE(PARITY_TYPE), .STOP_BITS(STOP_BITS)
    ) u_uart (
        .clk(clk_i), .rst(~rst_ni), .tx_data(core_tx_data), .tx_data_vld(core_tx_vld),
        .tx_active(core_tx_active), .tx_o(core_tx), .rx_i(core_rx), .rx_data(core_rx_data),
        .rx_data_vld(core_rx_vld), .rx_parity_err(core_perr)
    );
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed self-checking bench for wb_uart_fifo: 10 clocks/bit, 8N1, 4-entry FIFOs.
// Define UART_WB_LOOPBACK_EN to also exercise the internal loopback.

module tb_wb_uart_fifo;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    logic [7:0]  tx_q[$];
    int unsigned start_q[$];
    logic        stop_q[$];

    logic [31:0] rd;
    logic        ack, err;

    wb_uart_fifo #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_TYPE(0),
        .STOP_BITS(0), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Line decoder: samples each bit of an 8N1 frame in its middle.
    initial begin : line_monitor
        logic [7:0]  b;
        int unsigned t0;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && uart_tx_o === 1'b0) begin
                t0 = cyc;
                repeat (5) @(negedge clk_i);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk_i);
                    b[i] = uart_tx_o;
                end
                repeat (10) @(negedge clk_i);
                tx_q.push_back(b);
                start_q.push_back(t0);
                stop_q.push_back(uart_tx_o);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic ack_s, output logic err_s);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
        ack_s = 1'b0; err_s = 1'b0; rdat = '0;
        for (int i = 0; i < 4 && !(ack_s || err_s); i++) begin
            @(negedge clk_i);
            ack_s = wb_ack_o; err_s = wb_err_o; rdat = wb_dat_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic send_rx_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            uart_rx_i = f[i];
            repeat (9) @(negedge clk_i);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        if (tx_q.size() < n) begin
            failures++;
            $display("FAIL frame_wait: got %0d frames, expected %0d", tx_q.size(), n);
        end
    endtask

    task automatic clear_line();
        tx_q.delete(); start_q.delete(); stop_q.delete();
    endtask

    task automatic test_reset();
        logic seen;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        wb_stb_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) seen = 1'b1;
        end
        wb_stb_i = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL no_req_ack: got ack/err %b, expected 0", seen); end
        checks++;
        if (uart_tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx_idle: got %b, expected 1", uart_tx_o); end
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if ({ack, err} !== 2'b10) begin failures++; $display("FAIL status_ack: got ack=%b err=%b, expected 1 0", ack, err); end
        checks++;
        if (rd !== 32'h0000000A) begin failures++; $display("FAIL reset_status: got %h, expected 0000000a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        int unsigned gap;
        clear_line();
        wb_xfer(1'b1, 4'h0, 32'h55, rd, ack, err);
        checks++;
        if ({ack, err} !== 2'b10) begin failures++; $display("FAIL b2b_ack0: got ack=%b err=%b, expected 1 0", ack, err); end
        wb_xfer(1'b1, 4'h0, 32'hA3, rd, ack, err);
        checks++;
        if ({ack, err} !== 2'b10) begin failures++; $display("FAIL b2b_ack1: got ack=%b err=%b, expected 1 0", ack, err); end
        wait_frames(2, 400);
        b0 = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        b1 = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
        gap = (start_q.size() > 1) ? start_q[1] - start_q[0] : 0;
        checks++;
        if (b0 !== 8'h55) begin failures++; $display("FAIL b2b_byte0: got %h, expected 55", b0); end
        checks++;
        if (b1 !== 8'hA3) begin failures++; $display("FAIL b2b_byte1: got %h, expected a3", b1); end
        checks++;
        if (gap < 100 || gap > 104) begin failures++; $display("FAIL b2b_spacing: got %0d clocks, expected 100..104", gap); end
        checks++;
        if (stop_q.size() < 2 || stop_q[0] !== 1'b1 || stop_q[1] !== 1'b1) begin
            failures++; $display("FAIL b2b_stop: stop bits not 1, expected 1 1");
        end
        repeat (20) @(negedge clk_i);
    endtask

    task automatic test_tx_full();
        logic [7:0] exp_b [5];
        exp_b = '{8'h01, 8'h31, 8'h32, 8'h33, 8'h34};
        clear_line();
        wb_xfer(1'b1, 4'h0, 32'h01, rd, ack, err);
        repeat (10) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1'b1, 4'h0, 32'h31 + i, rd, ack, err);
            checks++;
            if ({ack, err} !== 2'b10) begin failures++; $display("FAIL fill_ack%0d: got ack=%b err=%b, expected 1 0", i, ack, err); end
        end
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h00040019) begin failures++; $display("FAIL full_status: got %h, expected 00040019", rd); end
        wb_xfer(1'b1, 4'h0, 32'h35, rd, ack, err);
        checks++;
        if ({ack, err} !== 2'b01) begin failures++; $display("FAIL full_err: got ack=%b err=%b, expected 0 1", ack, err); end
        wait_frames(5, 700);
        repeat (150) @(negedge clk_i);
        checks++;
        if (tx_q.size() != 5) begin failures++; $display("FAIL full_frames: got %0d frames, expected 5", tx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_q.size() <= i || tx_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL full_byte%0d: got %h, expected %h", i, (tx_q.size() > i) ? tx_q[i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] exp_d [5];
        exp_d = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h00};
        for (int i = 0; i < 5; i++) send_rx_byte(8'h11 + 8'(i));
        repeat (10) @(negedge clk_i);
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h00000426) begin failures++; $display("FAIL overrun_status: got %h, expected 00000426", rd); end
        for (int i = 0; i < 5; i++) begin
            wb_xfer(1'b0, 4'h0, '0, rd, ack, err);
            checks++;
            if (rd !== exp_d[i] || ack !== 1'b1) begin
                failures++; $display("FAIL rx_read%0d: got %h ack=%b, expected %h ack=1", i, rd, ack, exp_d[i]);
            end
        end
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h000000AA) begin failures++; $display("FAIL underrun_status: got %h, expected 000000aa", rd); end
        wb_xfer(1'b1, 4'h8, 32'h4, rd, ack, err);
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h0000000A) begin failures++; $display("FAIL flag_clear: got %h, expected 0000000a", rd); end
    endtask

    task automatic test_tx_flush();
        clear_line();
        wb_xfer(1'b1, 4'h0, 32'h7E, rd, ack, err);
        wb_xfer(1'b1, 4'h0, 32'h5A, rd, ack, err);
        wb_xfer(1'b1, 4'h0, 32'h5B, rd, ack, err);
        wb_xfer(1'b1, 4'h8, 32'h1, rd, ack, err);
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h0000001A) begin failures++; $display("FAIL flush_status: got %h, expected 0000001a", rd); end
        wb_xfer(1'b0, 4'h8, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL ctrl_read: got %h, expected 00000000", rd); end
        wait_frames(1, 300);
        repeat (150) @(negedge clk_i);
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h7E) begin
            failures++; $display("FAIL flush_frames: got %0d frames first %h, expected 1 frame 7e",
                                 tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
        end
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h0000000A) begin failures++; $display("FAIL flush_idle: got %h, expected 0000000a", rd); end
    endtask

`ifdef UART_WB_LOOPBACK_EN
    task automatic test_loopback();
        logic low_seen;
        wb_xfer(1'b1, 4'h8, 32'h8, rd, ack, err);
        wb_xfer(1'b0, 4'h8, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h8) begin failures++; $display("FAIL lb_ctrl: got %h, expected 00000008", rd); end
        low_seen = 1'b0;
        wb_xfer(1'b1, 4'h0, 32'hC3, rd, ack, err);
        repeat (130) begin
            @(negedge clk_i);
            if (uart_tx_o !== 1'b1) low_seen = 1'b1;
        end
        checks++;
        if (low_seen !== 1'b0) begin failures++; $display("FAIL lb_tx_held: got line low, expected 1 throughout"); end
        wb_xfer(1'b0, 4'h0, '0, rd, ack, err);
        checks++;
        if (rd !== 32'hC3) begin failures++; $display("FAIL lb_data: got %h, expected 000000c3", rd); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        wb_xfer(1'b1, 4'h0, 32'h3C, rd, ack, err);
        repeat (40) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (uart_tx_o !== 1'b1 || wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL async_reset: got tx=%b ack=%b, expected 1 0", uart_tx_o, wb_ack_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        wb_xfer(1'b0, 4'h4, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h0000000A) begin failures++; $display("FAIL reset_mid_status: got %h, expected 0000000a", rd); end
        wb_xfer(1'b0, 4'h8, '0, rd, ack, err);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_mid_ctrl: got %h, expected 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_tx_full();
        test_rx_overrun();
        test_tx_flush();
`ifdef UART_WB_LOOPBACK_EN
        test_loopback();
`endif
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
